rf_write_arbiter: RTL and testbench

Shares the register file's single write port between the in-order pipeline writeback stage and a long-latency unit (mul/div, multi-cycle loads). Buffers long-latency results in a small FIFO. Keeps a 32-bit pending-write scoreboard so decode stalls reads of registers whose value is still in flight. Sits between writeback/long-latency completion and the register file's write_enable/write_address/write_data inputs, and feeds the hazard/stall logic.

---
 rtl/rf_write_arbiter_if.sv | 41 ++++
 rtl/rf_write_arbiter.sv | 147 ++++++++++++++
 tb/tb_rf_write_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_write_arbiter_if.sv
// Purpose: bundles the writeback, long-latency, issue, decode and register-file signals of rf_write_arbiter.
// Latency: none, wiring only.
// Backpressure: carries pipe_hold (pipeline) and ll_valid/ll_ready (long-latency unit).
// Ports: slave = arbiter side, master = surrounding pipeline / register file side.
interface rf_write_arbiter_if;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_wdata;
    logic        pipe_hold;
    logic        ll_valid;
    logic        ll_ready;
    logic [4:0]  ll_rd;
    logic [31:0] ll_wdata;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        hazard_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pending;
    logic [3:0]  q_count;
    logic        sb_err;

    modport slave (
        input  pipe_we, pipe_rd, pipe_wdata, ll_valid, ll_rd, ll_wdata,
               issue_valid, issue_rd, rs1_addr, rs2_addr,
        output pipe_hold, ll_ready, rs1_busy, rs2_busy, hazard_stall,
               rf_we, rf_waddr, rf_wdata, pending, q_count, sb_err
    );

    modport master (
        output pipe_we, pipe_rd, pipe_wdata, ll_valid, ll_rd, ll_wdata,
               issue_valid, issue_rd, rs1_addr, rs2_addr,
        input  pipe_hold, ll_ready, rs1_busy, rs2_busy, hazard_stall,
               rf_we, rf_waddr, rf_wdata, pending, q_count, sb_err
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Purpose: shares the register-file write port between pipeline writeback and a long-latency unit; tracks pending writes.
// Latency: write-port selection is combinational (pipeline, FIFO pop or zero-latency ll bypass); scoreboard updates next edge.
// Backpressure: ll_ready drops when the FIFO is full; pipe_hold freezes the pipeline for one cycle to force a starved drain.
// Ports: clk, rst (sync, active-high); bus = rf_write_arbiter_if.slave carrying pipe_*, ll_*, issue_*, rs*_*, rf_*,
//        pending, q_count, sb_err.
module rf_write_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    rf_write_arbiter_if.slave    bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    logic [4:0]    fifo_rd  [DEPTH];
    logic [31:0]   fifo_dat [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [3:0]    q_count_r;
    logic [CW-1:0] starve_cnt;
    logic [31:0]   pending_r;
    logic          sb_err_r;
    logic          pipe_hold_r;

    logic          fifo_empty;
    logic          ll_ready_c;
    logic          pipe_live;
    logic          xfer;
    logic          pop;
    logic          bypass;
    logic          push;
    logic          ll_wr;
    logic [4:0]    ll_wr_rd;
    logic [31:0]   ll_wr_dat;
    logic          issue_set;
    logic [31:0]   pending_nxt;
    logic          err_now;
    logic          rf_we_c;
    logic [4:0]    rf_waddr_c;
    logic [31:0]   rf_wdata_c;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign fifo_empty = (q_count_r == 4'd0);
    assign ll_ready_c = !rst && (q_count_r < 4'(DEPTH));
    assign pipe_live  = bus.pipe_we && (bus.pipe_rd != 5'd0) && !pipe_hold_r;
    assign xfer       = bus.ll_valid && ll_ready_c;
    assign pop        = !pipe_live && !fifo_empty;
    // Bypass only when nothing is queued, so results can never overtake older FIFO entries.
    assign bypass     = !pipe_live && fifo_empty && xfer && (bus.ll_rd != 5'd0);
    assign push       = xfer && !bypass && (bus.ll_rd != 5'd0);
    assign ll_wr      = pop || bypass;
    assign ll_wr_rd   = pop ? fifo_rd[rptr]  : bus.ll_rd;
    assign ll_wr_dat  = pop ? fifo_dat[rptr] : bus.ll_wdata;
    assign issue_set  = bus.issue_valid && (bus.issue_rd != 5'd0);

    always_comb begin
        rf_we_c    = 1'b0;
        rf_waddr_c = 5'd0;
        rf_wdata_c = 32'd0;
        if (!rst) begin
            if (pipe_live) begin
                rf_we_c    = 1'b1;
                rf_waddr_c = bus.pipe_rd;
                rf_wdata_c = bus.pipe_wdata;
            end else if (ll_wr) begin
                rf_we_c    = 1'b1;
                rf_waddr_c = ll_wr_rd;
                rf_wdata_c = ll_wr_dat;
            end
        end
    end

    // Clear first, then set, so a same-cycle issue to the retiring rd keeps the bit.
    always_comb begin
        pending_nxt = pending_r;
        if (ll_wr) begin
            pending_nxt[ll_wr_rd] = 1'b0;
        end
        if (issue_set) begin
            pending_nxt[bus.issue_rd] = 1'b1;
        end
    end

    // Re-issuing an rd whose old result retires this very cycle is legal back-to-back use, not an error.
    assign err_now = (issue_set && pending_r[bus.issue_rd] && !(ll_wr && (ll_wr_rd == bus.issue_rd)))
                   || (pipe_live && pending_r[bus.pipe_rd])
                   || (ll_wr && !pending_r[ll_wr_rd]);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wptr]  <= bus.ll_rd;
            fifo_dat[wptr] <= bus.ll_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr        <= '0;
            rptr        <= '0;
            q_count_r   <= 4'd0;
            starve_cnt  <= '0;
            pending_r   <= 32'd0;
            sb_err_r    <= 1'b0;
            pipe_hold_r <= 1'b0;
        end else begin
            if (push) begin
                wptr <= ptr_inc(wptr);
            end
            if (pop) begin
                rptr <= ptr_inc(rptr);
            end
            case ({push, pop})
                2'b10:   q_count_r <= q_count_r + 4'd1;
                2'b01:   q_count_r <= q_count_r - 4'd1;
                default: q_count_r <= q_count_r;
            endcase
            // Counter saturates at the limit; the hold cycle that follows pops and clears it.
            if (pop || fifo_empty) begin
                starve_cnt <= '0;
            end else if (pipe_live && (starve_cnt < CW'(STARVE_LIMIT))) begin
                starve_cnt <= starve_cnt + CW'(1);
            end
            pipe_hold_r <= (starve_cnt == CW'(STARVE_LIMIT)) && !pop;
            pending_r   <= pending_nxt;
            if (err_now) begin
                sb_err_r <= 1'b1;
            end
        end
    end

    assign bus.ll_ready     = ll_ready_c;
    assign bus.pipe_hold    = pipe_hold_r;
    assign bus.rf_we        = rf_we_c;
    assign bus.rf_waddr     = rf_waddr_c;
    assign bus.rf_wdata     = rf_wdata_c;
    assign bus.pending      = pending_r;
    assign bus.q_count      = q_count_r;
    assign bus.sb_err       = sb_err_r;
    assign bus.rs1_busy     = pending_r[bus.rs1_addr] && (bus.rs1_addr != 5'd0);
    assign bus.rs2_busy     = pending_r[bus.rs2_addr] && (bus.rs2_addr != 5'd0);
    assign bus.hazard_stall = bus.rs1_busy || bus.rs2_busy;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Purpose: directed self-checking bench for rf_write_arbiter (DEPTH=2, STARVE_LIMIT=4).
// Latency: inputs driven 1ns after the rising edge, outputs observed 1ns later.
// Backpressure: long-latency source follows ll_ready; pipeline is driven open-loop.
module tb_rf_write_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    rf_write_arbiter_if bus();

    rf_write_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        bus.pipe_we     = 1'b0;
        bus.pipe_rd     = 5'd0;
        bus.pipe_wdata  = 32'd0;
        bus.ll_valid    = 1'b0;
        bus.ll_rd       = 5'd0;
        bus.ll_wdata    = 32'd0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = 5'd0;
        bus.rs1_addr    = 5'd0;
        bus.rs2_addr    = 5'd0;
    endtask

    task automatic issue(input logic [4:0] rd);
        idle();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = rd;
        tick();
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int seen;
        int maxq;

        // Reset held two edges with requests active on both sides.
        idle();
        rst             = 1'b1;
        bus.pipe_we     = 1'b1;
        bus.pipe_rd     = 5'd3;
        bus.pipe_wdata  = 32'h3333;
        bus.ll_valid    = 1'b1;
        bus.ll_rd       = 5'd2;
        bus.ll_wdata    = 32'h2222;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_rf_we",    bus.rf_we,    32'd0);
            check("rst_ll_ready", bus.ll_ready, 32'd0);
            check("rst_pending",  bus.pending,  32'd0);
            check("rst_q_count",  bus.q_count,  32'd0);
        end
        check("rst_pipe_hold", bus.pipe_hold, 32'd0);
        check("rst_sb_err",    bus.sb_err,    32'd0);
        rst = 1'b0;
        idle();
        settle();
        check("post_rst_ll_ready", bus.ll_ready, 32'd1);

        // Bypass: zero-latency write of a pending register.
        issue(5'd5);
        bus.rs1_addr = 5'd5;
        settle();
        check("byp_pending_set", bus.pending,      32'h0000_0020);
        check("byp_rs1_busy",    bus.rs1_busy,     32'd1);
        check("byp_hazard",      bus.hazard_stall, 32'd1);
        bus.ll_valid = 1'b1;
        bus.ll_rd    = 5'd5;
        bus.ll_wdata = 32'hDEAD_BEEF;
        settle();
        check("byp_rf_we",    bus.rf_we,    32'd1);
        check("byp_rf_waddr", bus.rf_waddr, 32'd5);
        check("byp_rf_wdata", bus.rf_wdata, 32'hDEAD_BEEF);
        check("byp_rs1_busy_same", bus.rs1_busy, 32'd1);
        tick();
        idle();
        bus.rs1_addr = 5'd5;
        settle();
        check("byp_pending_clr", bus.pending,  32'd0);
        check("byp_rs1_free",    bus.rs1_busy, 32'd0);
        check("byp_q_count",     bus.q_count,  32'd0);

        // Conflict: pipeline owns the port while ll results queue up.
        issue(5'd7);
        issue(5'd8);
        issue(5'd9);
        bus.pipe_we = 1'b1; bus.pipe_rd = 5'd1; bus.pipe_wdata = 32'h111;
        bus.ll_valid = 1'b1; bus.ll_rd = 5'd7; bus.ll_wdata = 32'h700;
        settle();
        check("cf_a_waddr",    bus.rf_waddr, 32'd1);
        check("cf_a_wdata",    bus.rf_wdata, 32'h111);
        check("cf_a_ll_ready", bus.ll_ready, 32'd1);
        tick();
        bus.pipe_rd = 5'd2; bus.pipe_wdata = 32'h222;
        bus.ll_rd = 5'd8; bus.ll_wdata = 32'h800;
        settle();
        check("cf_b_q_count", bus.q_count,  32'd1);
        check("cf_b_waddr",   bus.rf_waddr, 32'd2);
        tick();
        bus.pipe_rd = 5'd3; bus.pipe_wdata = 32'h333;
        bus.ll_rd = 5'd9; bus.ll_wdata = 32'h900;
        settle();
        check("cf_c_q_count",  bus.q_count,  32'd2);
        check("cf_c_ll_ready", bus.ll_ready, 32'd0);
        check("cf_c_waddr",    bus.rf_waddr, 32'd3);
        tick();
        bus.pipe_we = 1'b0;
        settle();
        check("cf_d_waddr",    bus.rf_waddr, 32'd7);
        check("cf_d_wdata",    bus.rf_wdata, 32'h700);
        check("cf_d_ll_ready", bus.ll_ready, 32'd0);
        tick();
        settle();
        check("cf_e_q_count",  bus.q_count,  32'd1);
        check("cf_e_ll_ready", bus.ll_ready, 32'd1);
        check("cf_e_waddr",    bus.rf_waddr, 32'd8);
        check("cf_e_wdata",    bus.rf_wdata, 32'h800);
        tick();
        bus.ll_valid = 1'b0;
        settle();
        check("cf_f_waddr", bus.rf_waddr, 32'd9);
        check("cf_f_wdata", bus.rf_wdata, 32'h900);
        tick();
        idle();
        settle();
        check("cf_q_empty", bus.q_count, 32'd0);
        check("cf_pending", bus.pending, 32'd0);
        check("cf_sb_err",  bus.sb_err,  32'd0);

        // Starvation: FIFO holds rd=10 while the pipeline writes every cycle.
        issue(5'd10);
        bus.pipe_we = 1'b1; bus.pipe_rd = 5'd11; bus.pipe_wdata = 32'hB0;
        bus.ll_valid = 1'b1; bus.ll_rd = 5'd10; bus.ll_wdata = 32'hA0A0;
        settle();
        check("st_s0_waddr", bus.rf_waddr, 32'd11);
        tick();
        bus.ll_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.pipe_rd    = 5'(12 + i);
            bus.pipe_wdata = 32'(i);
            settle();
            check("st_hold",  bus.pipe_hold, (i == 5) ? 32'd1 : 32'd0);
            check("st_waddr", bus.rf_waddr,  (i == 5) ? 32'd10 : 32'(12 + i));
            if (i == 5) begin
                check("st_wdata", bus.rf_wdata, 32'hA0A0);
            end
            tick();
        end
        idle();
        settle();
        check("st_q_empty", bus.q_count, 32'd0);
        check("st_pending", bus.pending, 32'd0);
        check("st_sb_err",  bus.sb_err,  32'd0);

        // x0 is never tracked.
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd0;
        settle();
        check("x0_rs1_busy", bus.rs1_busy, 32'd0);
        tick();
        check("x0_pending",  bus.pending,  32'd0);
        check("x0_rs2_busy", bus.rs2_busy, 32'd0);
        idle();

        // Same-cycle issue and retire of rd=6: the set wins.
        issue(5'd6);
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd6;
        bus.ll_valid = 1'b1; bus.ll_rd = 5'd6; bus.ll_wdata = 32'h66;
        settle();
        check("sim_rf_we",    bus.rf_we,    32'd1);
        check("sim_rf_waddr", bus.rf_waddr, 32'd6);
        tick();
        idle();
        bus.rs2_addr = 5'd6;
        settle();
        check("sim_pending",  bus.pending,      32'h0000_0040);
        check("sim_rs2_busy", bus.rs2_busy,     32'd1);
        check("sim_hazard",   bus.hazard_stall, 32'd1);
        check("sim_sb_err",   bus.sb_err,       32'd0);
        bus.ll_valid = 1'b1; bus.ll_rd = 5'd6; bus.ll_wdata = 32'h67;
        tick();
        idle();
        settle();
        check("sim_pending_clr", bus.pending, 32'd0);

        // Wrap: six results through a two-entry FIFO with alternating pipeline traffic.
        for (int r = 20; r < 26; r++) begin
            issue(5'(r));
        end
        sent = 0;
        seen = 0;
        maxq = 0;
        for (int c = 0; c < 40; c++) begin
            bus.ll_valid   = (sent < 6);
            bus.ll_rd      = 5'(20 + sent);
            bus.ll_wdata   = 32'hC000 + 32'(sent);
            bus.pipe_we    = (c % 2 == 1);
            bus.pipe_rd    = 5'd1;
            bus.pipe_wdata = 32'(c);
            settle();
            if (int'(bus.q_count) > maxq) begin
                maxq = int'(bus.q_count);
            end
            if (bus.rf_we && (bus.rf_waddr != 5'd1)) begin
                check("wrap_waddr", bus.rf_waddr, 32'(20 + seen));
                check("wrap_wdata", bus.rf_wdata, 32'hC000 + 32'(seen));
                seen++;
            end
            if (bus.ll_valid && bus.ll_ready) begin
                sent++;
            end
            tick();
        end
        idle();
        settle();
        check("wrap_written", 32'(seen), 32'd6);
        check("wrap_q_bound", (maxq <= 2) ? 32'd1 : 32'd0, 32'd1);
        check("wrap_pending", bus.pending, 32'd0);
        check("wrap_sb_err",  bus.sb_err,  32'd0);

        // Double issue to rd=4 raises a sticky error.
        issue(5'd4);
        settle();
        check("dbl_sb_err_first", bus.sb_err, 32'd0);
        issue(5'd4);
        settle();
        check("dbl_sb_err", bus.sb_err, 32'd1);
        tick();
        tick();
        check("dbl_sb_err_sticky", bus.sb_err,  32'd1);
        check("dbl_pending",       bus.pending, 32'h0000_0010);

        // Reset mid-operation discards queue and scoreboard.
        bus.pipe_we = 1'b1; bus.pipe_rd = 5'd1; bus.pipe_wdata = 32'h1;
        bus.ll_valid = 1'b1; bus.ll_rd = 5'd13; bus.ll_wdata = 32'hD0;
        tick();
        bus.ll_rd = 5'd14; bus.ll_wdata = 32'hE0;
        tick();
        check("mid_q_full", bus.q_count, 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        settle();
        check("mid_q_count", bus.q_count, 32'd0);
        check("mid_pending", bus.pending, 32'd0);
        check("mid_sb_err",  bus.sb_err,  32'd0);
        check("mid_rf_we",   bus.rf_we,   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
